// File: rtl/mult_sched_kca_pkg.sv
// Shared definitions for the multiplier scheduler.
//   - State encoding of the scheduler FSM. The raw constants are kept for
//     legacy code that compares against plain bit patterns.
//   - DEFAULT_WIDTH: default operand width.
//   - prod_w(): width of the multiplier product (2*WIDTH+1).
package mult_sched_kca_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
    localparam logic [1:0] ST_LAUNCH_ENC = 2'd1;
    localparam logic [1:0] ST_WAIT_ENC   = 2'd2;
    localparam logic [1:0] ST_DONE_ENC   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = ST_IDLE_ENC,
        ST_LAUNCH = ST_LAUNCH_ENC,
        ST_WAIT   = ST_WAIT_ENC,
        ST_DONE   = ST_DONE_ENC
    } state_e;

    function automatic int prod_w(input int width);
        return 2 * width + 1;
    endfunction

endpackage

// File: rtl/rr_pick_kca.sv
// Combinational round-robin picker.
// Ports:
//   req_i   [N_REQ]  request levels
//   last_i  [IDX_W]  index of the most recently served requester
//   grant_o [IDX_W]  first requester with a set bit, searching circularly
//                    from (last_i+1) mod N_REQ
//   valid_o          at least one request is set
module rr_pick_kca
    import mult_sched_kca_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [IDX_W-1:0] grant_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] cand;

    // Walk the circular distance from far to near so that the nearest
    // requester after last_i is the one left standing.
    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last_i) + k) % N_REQ);
            if (req_i[cand]) begin
                grant_o = cand;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_sched_kca.sv
// Round-robin scheduler sharing one Multiplicador_KCA among N_REQ requesters.
// Ports:
//   Clock, Reset        clock, synchronous active-high reset
//   Req[N_REQ]          request levels; OpA/OpB hold N_REQ flattened operands
//   Done[N_REQ]         one-cycle completion pulse to the served requester
//   Result              product of the last completed job (held)
//   Error               one-cycle timeout pulse, coincident with Done
//   M_Start, M_Multiplicando, M_Multiplicador   drive the shared multiplier
//   M_Ready, M_Producto                          multiplier status and product
// Optional feature: define MULT_SCHED_TIMEOUT_EN to enable a WAIT watchdog of
// TIMEOUT_CYCLES cycles; otherwise WAIT waits forever and Error is tied 0.
module mult_sched_kca
    import mult_sched_kca_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int WIDTH          = DEFAULT_WIDTH,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [N_REQ-1:0]         Req,
    input  logic [N_REQ*WIDTH-1:0]   OpA,
    input  logic [N_REQ*WIDTH-1:0]   OpB,
    output logic [N_REQ-1:0]         Done,
    output logic [prod_w(WIDTH)-1:0] Result,
    output logic                     Error,
    output logic                     M_Start,
    output logic [WIDTH-1:0]         M_Multiplicando,
    output logic [WIDTH-1:0]         M_Multiplicador,
    input  logic                     M_Ready,
    input  logic [prod_w(WIDTH)-1:0] M_Producto
);

    localparam int PW    = prod_w(WIDTH);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             start_q, start_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [PW-1:0]    result_q, result_d;
    logic             busy_seen_q, busy_seen_d;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_vld;

`ifdef MULT_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;
`endif

    rr_pick_kca #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i   (Req),
        .last_i  (last_q),
        .grant_o (pick_idx),
        .valid_o (pick_vld)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        last_d      = last_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        start_d     = 1'b0;
        done_d      = '0;
        result_d    = result_q;
        busy_seen_d = busy_seen_q;
`ifdef MULT_SCHED_TIMEOUT_EN
        wd_d        = wd_q;
        err_d       = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                // Latch operands here so they are already stable on the
                // multiplier port during the Start cycle.
                if (pick_vld) begin
                    idx_d   = pick_idx;
                    opa_d   = OpA[int'(pick_idx)*WIDTH +: WIDTH];
                    opb_d   = OpB[int'(pick_idx)*WIDTH +: WIDTH];
                    start_d = 1'b1;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                busy_seen_d = 1'b0;
`ifdef MULT_SCHED_TIMEOUT_EN
                wd_d        = '0;
`endif
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                // Ready may still be high from the previous job; only a rise
                // after an observed busy phase marks completion.
                if (M_Ready && busy_seen_q) begin
                    result_d      = M_Producto;
                    done_d[idx_q] = 1'b1;
                    state_d       = ST_DONE;
                end else begin
                    if (!M_Ready) begin
                        busy_seen_d = 1'b1;
                    end
`ifdef MULT_SCHED_TIMEOUT_EN
                    if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        result_d      = '0;
                        done_d[idx_q] = 1'b1;
                        err_d         = 1'b1;
                        state_d       = ST_DONE;
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
`endif
                end
            end
            ST_DONE: begin
                last_d  = idx_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            last_q      <= IDX_W'(N_REQ - 1);
            opa_q       <= '0;
            opb_q       <= '0;
            start_q     <= 1'b0;
            done_q      <= '0;
            result_q    <= '0;
            busy_seen_q <= 1'b0;
`ifdef MULT_SCHED_TIMEOUT_EN
            wd_q        <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            start_q     <= start_d;
            done_q      <= done_d;
            result_q    <= result_d;
            busy_seen_q <= busy_seen_d;
`ifdef MULT_SCHED_TIMEOUT_EN
            wd_q        <= wd_d;
            err_q       <= err_d;
`endif
        end
    end

    assign Done            = done_q;
    assign Result          = result_q;
    assign M_Start         = start_q;
    assign M_Multiplicando = opa_q;
    assign M_Multiplicador = opb_q;
`ifdef MULT_SCHED_TIMEOUT_EN
    assign Error           = err_q;
`else
    assign Error           = 1'b0;
`endif

endmodule

// File: tb/tb_mult_sched_kca.sv
module tb_mult_sched_kca;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int PW = 17;
    localparam int TO = 64;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req;
    logic [N*W-1:0] opa, opb;
    logic [N-1:0]  done;
    logic [PW-1:0] result;
    logic          err;
    logic          m_start;
    logic [W-1:0]  m_a, m_b;
    logic          m_ready;
    logic [PW-1:0] m_prod;

    int checks   = 0;
    int failures = 0;
    int n_start  = 0;

    // multiplier model configuration
    int cfg_pre   = 0;
    int cfg_busy  = 2;
    bit cfg_stuck = 0;

    mult_sched_kca #(
        .N_REQ          (N),
        .WIDTH          (W),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .Clock           (clk),
        .Reset           (rst),
        .Req             (req),
        .OpA             (opa),
        .OpB             (opb),
        .Done            (done),
        .Result          (result),
        .Error           (err),
        .M_Start         (m_start),
        .M_Multiplicando (m_a),
        .M_Multiplicador (m_b),
        .M_Ready         (m_ready),
        .M_Producto      (m_prod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr(input logic [N-1:0] r, input int l);
        for (int k = 1; k <= N; k++)
            if (r[(l + k) % N]) return (l + k) % N;
        return 0;
    endfunction

    // Shared multiplier model: samples Start at the falling edge, reacts just
    // after the rising edge. Ready stays high cfg_pre WAIT cycles, then low
    // for cfg_busy cycles, then rises with the product. Junk on the product
    // bus whenever the result is not yet valid.
    initial begin
        int phase, pre, busy;
        logic [PW-1:0] prod;
        logic s_start, s_rst;
        logic [W-1:0] sa, sb;
        phase = 0; pre = 0; busy = 0; prod = '0;
        m_ready = 1'b1;
        m_prod  = '0;
        forever begin
            @(negedge clk);
            s_start = m_start; s_rst = rst; sa = m_a; sb = m_b;
            @(posedge clk); #1;
            if (s_rst) begin
                phase = 0;
                m_ready = 1'b1;
            end else begin
                if (phase == 0 && s_start === 1'b1) begin
                    prod  = PW'(sa) * PW'(sb);
                    pre   = cfg_pre;
                    phase = 1;
                end
                if (phase == 1) begin
                    m_prod = PW'($urandom);
                    if (pre == 0) begin
                        m_ready = 1'b0;
                        busy    = cfg_busy;
                        phase   = cfg_stuck ? 3 : 2;
                    end else begin
                        pre--;
                    end
                end else if (phase == 2) begin
                    if (busy <= 1) begin
                        m_ready = 1'b1;
                        m_prod  = prod;
                        phase   = 0;
                    end else begin
                        busy--;
                        m_prod = PW'($urandom);
                    end
                end
            end
        end
    end

    // Reference model and per-cycle comparison. st is the position of the
    // current cycle in a job: 0 idle, 1 start cycle, 2 waiting, 3 done cycle.
    int st = 0, idx = 0, last = N - 1, wc = 0;
    bit seen = 0, err_e = 0, rst_prev = 0;
    logic [W-1:0]  la = '0, lb = '0;
    logic [PW-1:0] prod_e = '0, res_e = '0;

    always @(negedge clk) begin
        if (m_start === 1'b1) n_start++;
        if (rst_prev) begin
            chk("rst_done",   32'(done),    32'(0));
            chk("rst_result", 32'(result),  32'(0));
            chk("rst_start",  32'(m_start), 32'(0));
            chk("rst_opa",    32'(m_a),     32'(0));
            chk("rst_opb",    32'(m_b),     32'(0));
            chk("rst_error",  32'(err),     32'(0));
            st = 0; last = N - 1; res_e = '0;
        end else begin
            chk("start", 32'(m_start), 32'(st == 1));
            chk("done",  32'(done),    32'((st == 3) ? (4'b0001 << idx) : 4'b0000));
            chk("error", 32'(err),     32'(st == 3 && err_e));
            if (st == 3) res_e = err_e ? '0 : prod_e;
            chk("result", 32'(result), 32'(res_e));
            if (st != 0) begin
                chk("hold_a", 32'(m_a), 32'(la));
                chk("hold_b", 32'(m_b), 32'(lb));
            end
        end
        case (st)
            0: if (!rst && req != '0) begin
                idx    = rr(req, last);
                la     = opa[idx*W +: W];
                lb     = opb[idx*W +: W];
                prod_e = PW'(la) * PW'(lb);
                st     = 1;
            end
            1: begin st = 2; seen = 0; wc = 0; end
            2: begin
                wc++;
                if (m_ready && seen) begin
                    st = 3; err_e = 0;
                end
`ifdef MULT_SCHED_TIMEOUT_EN
                else if (wc == TO) begin
                    st = 3; err_e = 1;
                end
`endif
                else if (!m_ready) seen = 1;
            end
            3: begin last = idx; st = 0; end
            default: st = 0;
        endcase
        rst_prev = rst;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic wait_done(output logic [N-1:0] d, output logic [PW-1:0] r, output logic e);
        int n;
        n = 0;
        while (n < 400) begin
            @(negedge clk);
            if (done != '0) break;
            n++;
        end
        checks++;
        if (done == '0) begin
            failures++;
            $display("FAIL wait_done no Done within 400 cycles");
        end
        d = done; r = result; e = err;
        @(posedge clk); #1;
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            if (m_start === 1'b1) break;
            n++;
        end
        checks++;
        if (m_start !== 1'b1) begin
            failures++;
            $display("FAIL wait_start no M_Start within 50 cycles");
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [N-1:0]  d;
        logic [PW-1:0] r;
        logic          e;
        int            s0, nd;
        bit            e_seen;
        logic [N-1:0]  exp_order [5];
        logic [PW-1:0] exp_res   [5];
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_res   = '{17'd30, 17'd100, 17'd210, 17'd360, 17'd30};

        rst = 1'b1; req = '0; opa = '0; opb = '0;
        tick(3);
        rst = 1'b0;

        // single requester 0
        s0 = n_start;
        req = 4'b0001; opa[7:0] = 8'hDF; opb[7:0] = 8'hD7;
        wait_done(d, r, e);
        chk("t1_done",   32'(d), 32'(4'b0001));
        chk("t1_result", 32'(r), 32'(17'h0BB49));
        chk("t1_starts", 32'(n_start - s0), 32'(1));
        req = '0;
        tick(3);

        // all four requesting from reset release
        req = 4'b1111;
        opa = {8'd40, 8'd30, 8'd20, 8'd10};
        opb = {8'd9,  8'd7,  8'd5,  8'd3};
        do_reset();
        for (int j = 0; j < 5; j++) begin
            wait_done(d, r, e);
            chk("t2_order",  32'(d), 32'(exp_order[j]));
            chk("t2_result", 32'(r), 32'(exp_res[j]));
        end
        req = '0;
        tick(4);

        // lone requester 2, back-to-back
        opa[23:16] = 8'hFF; opb[23:16] = 8'hFF;
        req = 4'b0100;
        for (int j = 0; j < 3; j++) begin
            wait_done(d, r, e);
            chk("t3_done",   32'(d), 32'(4'b0100));
            chk("t3_result", 32'(r), 32'(17'h0FE01));
        end
        req = '0;
        tick(3);

        // reset in the middle of WAIT, then a clean job
        cfg_busy = 6;
        opa[15:8] = 8'd12; opb[15:8] = 8'd11;
        req = 4'b0010;
        wait_start();
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        wait_done(d, r, e);
        chk("t4_done",   32'(d), 32'(4'b0010));
        chk("t4_result", 32'(r), 32'(17'd132));
        req = '0;
        cfg_busy = 2;
        tick(3);

        // Ready still high for two WAIT cycles before the busy phase
        cfg_pre = 2;
        opa[31:24] = 8'd200; opb[31:24] = 8'd100;
        req = 4'b1000;
        wait_done(d, r, e);
        chk("t5_done",   32'(d), 32'(4'b1000));
        chk("t5_result", 32'(r), 32'(17'h04E20));
        req = '0;
        cfg_pre = 0;
        tick(3);

        // randomized traffic with occasional resets
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
            opa      = $urandom;
            opb      = $urandom;
            cfg_pre  = $urandom_range(0, 2);
            cfg_busy = $urandom_range(1, 4);
            rst      = ($urandom_range(0, 199) == 0);
            tick(1);
        end
        rst = 1'b0; req = '0; cfg_pre = 0; cfg_busy = 2;
        do_reset();
        tick(2);

        // multiplier never finishes; requester drops Req mid-job
        cfg_stuck = 1;
        opa[7:0] = 8'd5; opb[7:0] = 8'd6;
        req = 4'b0001;
        wait_start();
        req = '0;
        nd = 0; e_seen = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done != '0) begin
                nd++;
                if (err) e_seen = 1;
                chk("t7_done_bit",   32'(done),   32'(4'b0001));
                chk("t7_result_zero", 32'(result), 32'(0));
            end
        end
`ifdef MULT_SCHED_TIMEOUT_EN
        chk("t7_timeouts", 32'(nd), 32'(1));
        chk("t7_error",    32'(e_seen), 32'(1));
`else
        chk("t7_no_done",  32'(nd), 32'(0));
        chk("t7_no_error", 32'(e_seen), 32'(0));
`endif
        @(posedge clk); #1;
        cfg_stuck = 0;
        do_reset();
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
